// File: rtl/riscv_mp_rf_if.sv
// Register file port bundle: read/pending-check side from issue, write side from writeback.
interface riscv_mp_rf_if #(
  parameter int NUM_REGS     = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 1
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [NUM_RD_PORTS*ADDR_W-1:0]     rd_addr;
  logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD_PORTS-1:0]            rd_busy;
  logic [NUM_WR_PORTS-1:0]            wr_en;
  logic [NUM_WR_PORTS*ADDR_W-1:0]     wr_addr;
  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wr_data;
  logic                               pend_set;
  logic [ADDR_W-1:0]                  pend_addr;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, pend_set, pend_addr,
    input  rd_data, rd_busy
  );
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, pend_set, pend_addr,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/riscv_mp_rf.sv
// Multi-port integer register file with optional write-to-read bypass and per-register pending bits.
module riscv_mp_rf_rd_lane #(
  parameter int NUM_REGS     = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_WR_PORTS = 1,
  parameter int BYPASS       = 1,
  parameter int ADDR_W       = 5
) (
  input  logic                               rst_n,
  input  logic [ADDR_W-1:0]                  addr,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem,
  input  logic [NUM_REGS-1:0]                pend,
  input  logic [NUM_WR_PORTS-1:0]            wr_en,
  input  logic [NUM_WR_PORTS*ADDR_W-1:0]     wr_addr,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic                               pend_set,
  input  logic [ADDR_W-1:0]                  pend_addr,
  output logic [DATA_WIDTH-1:0]              data,
  output logic                               busy
);
  logic                  hit;
  logic [DATA_WIDTH-1:0] byp;

  // Ascending scan so the highest-index matching write port wins.
  always_comb begin
    hit = 1'b0;
    byp = '0;
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == addr) begin
        hit = 1'b1;
        byp = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (addr == '0) hit = 1'b0;
  end

  // Reset gating keeps a write presented during reset from leaking through the bypass.
  always_comb begin
    data = '0;
    busy = pend[addr];
    if (rst_n) begin
      if (BYPASS != 0 && hit) data = byp;
      else                    data = mem[addr];
    end
    if (BYPASS != 0 && hit && !(pend_set && pend_addr == addr)) busy = 1'b0;
  end
endmodule

module riscv_mp_rf #(
  parameter int NUM_REGS     = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 1,
  parameter int BYPASS       = 1
) (
  input logic           clk,
  input logic           rst_n,
  riscv_mp_rf_if.slave  bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem;
  logic [NUM_REGS-1:0]                 pend;

  assign mem[0]  = '0;
  assign pend[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic                  we;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] q;
    logic                  p;

    always_comb begin
      we = 1'b0;
      wd = '0;
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
        if (bus.wr_en[w] && bus.wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
          we = 1'b1;
          wd = bus.wr_data[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= '0;
      else if (we) q <= wd;
    end

    // A new producer issued in the same cycle as the old one retires keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                           p <= 1'b0;
      else if (bus.pend_set && bus.pend_addr == ADDR_W'(r)) p <= 1'b1;
      else if (we)                                          p <= 1'b0;
    end

    assign mem[r]  = q;
    assign pend[r] = p;
  end

  for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd
    riscv_mp_rf_rd_lane #(
      .NUM_REGS     (NUM_REGS),
      .DATA_WIDTH   (DATA_WIDTH),
      .NUM_WR_PORTS (NUM_WR_PORTS),
      .BYPASS       (BYPASS),
      .ADDR_W       (ADDR_W)
    ) u_lane (
      .rst_n     (rst_n),
      .addr      (bus.rd_addr[i*ADDR_W +: ADDR_W]),
      .mem       (mem),
      .pend      (pend),
      .wr_en     (bus.wr_en),
      .wr_addr   (bus.wr_addr),
      .wr_data   (bus.wr_data),
      .pend_set  (bus.pend_set),
      .pend_addr (bus.pend_addr),
      .data      (bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .busy      (bus.rd_busy[i])
    );
  end
endmodule

// File: tb/tb_riscv_mp_rf.sv
// Directed checks of riscv_mp_rf: 16 regs / 8 read / 2 write with bypass, plus a no-bypass instance.
module tb_riscv_mp_rf;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  riscv_mp_rf_if #(.NUM_REGS(16), .DATA_WIDTH(32), .NUM_RD_PORTS(8), .NUM_WR_PORTS(2)) ifa ();
  riscv_mp_rf_if #(.NUM_REGS(16), .DATA_WIDTH(32), .NUM_RD_PORTS(2), .NUM_WR_PORTS(1)) ifb ();

  riscv_mp_rf #(.NUM_REGS(16), .DATA_WIDTH(32), .NUM_RD_PORTS(8), .NUM_WR_PORTS(2), .BYPASS(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  riscv_mp_rf #(.NUM_REGS(16), .DATA_WIDTH(32), .NUM_RD_PORTS(2), .NUM_WR_PORTS(1), .BYPASS(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifa.wr_en = '0;
    ifa.pend_set = 1'b0;
    ifa.pend_addr = '0;
    ifb.wr_en = '0;
    ifb.pend_set = 1'b0;
    ifb.pend_addr = '0;
  endtask

  task automatic wr_a(input int port, input logic [3:0] a, input logic [31:0] d);
    ifa.wr_en[port] = 1'b1;
    ifa.wr_addr[port*4 +: 4] = a;
    ifa.wr_data[port*32 +: 32] = d;
  endtask

  task automatic set_a(input logic [3:0] a);
    ifa.pend_set = 1'b1;
    ifa.pend_addr = a;
  endtask

  task automatic ra(input int port, input logic [3:0] a);
    ifa.rd_addr[port*4 +: 4] = a;
  endtask

  function automatic logic [31:0] da(input int port);
    return ifa.rd_data[port*32 +: 32];
  endfunction

  initial begin
    ifa.rd_addr = '0;
    ifa.wr_addr = '0;
    ifa.wr_data = '0;
    ifb.rd_addr = '0;
    ifb.wr_addr = '0;
    ifb.wr_data = '0;
    idle();
    ra(0, 4'd5);
    #12;
    chk("rst_data", da(0), 32'h0);
    chk("rst_busy", {31'b0, ifa.rd_busy[0]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset clears a loaded, pending register between edges
    wr_a(0, 4'd5, 32'hDEADBEEF);
    tick();
    idle();
    set_a(4'd5);
    tick();
    idle();
    #1;
    chk("x5_loaded", da(0), 32'hDEADBEEF);
    chk("x5_busy", {31'b0, ifa.rd_busy[0]}, 32'h1);
    rst_n = 1'b0;
    wr_a(0, 4'd6, 32'h12345678);
    ra(1, 4'd6);
    #1;
    chk("rst_async_data", da(0), 32'h0);
    chk("rst_async_busy", {31'b0, ifa.rd_busy[0]}, 32'h0);
    chk("rst_no_bypass", da(1), 32'h0);
    tick();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_write_lost", da(1), 32'h0);

    // x0 never stores or goes pending
    for (int p = 0; p < 8; p++) ra(p, 4'd0);
    wr_a(0, 4'd0, 32'hFFFFFFFF);
    set_a(4'd0);
    #1;
    chk("x0_bypass", da(0), 32'h0);
    tick();
    idle();
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("x0_data_p%0d", p), da(p), 32'h0);
      chk($sformatf("x0_busy_p%0d", p), {31'b0, ifa.rd_busy[p]}, 32'h0);
    end

    // two ports hit x7: port1 wins, also on the bypass path
    wr_a(0, 4'd7, 32'h11);
    wr_a(1, 4'd7, 32'h22);
    ra(1, 4'd7);
    #1;
    chk("conflict_bypass", da(1), 32'h22);
    tick();
    idle();
    chk("conflict_stored", da(1), 32'h22);

    // bypass enabled
    wr_a(0, 4'd3, 32'h1);
    tick();
    idle();
    ra(0, 4'd3);
    #1;
    chk("byp_old", da(0), 32'h1);
    wr_a(0, 4'd3, 32'hA5A5);
    #1;
    chk("byp_same_cycle", da(0), 32'hA5A5);
    tick();
    idle();
    chk("byp_next", da(0), 32'hA5A5);

    // bypass disabled
    ifb.wr_en[0] = 1'b1;
    ifb.wr_addr = 4'd3;
    ifb.wr_data = 32'h1;
    tick();
    ifb.wr_data = 32'hA5A5;
    ifb.rd_addr[3:0] = 4'd3;
    #1;
    chk("nobyp_same_cycle", ifb.rd_data[31:0], 32'h1);
    tick();
    idle();
    chk("nobyp_next", ifb.rd_data[31:0], 32'hA5A5);

    // scoreboard on x9
    ra(0, 4'd9);
    set_a(4'd9);
    #1;
    chk("sb_before_set", {31'b0, ifa.rd_busy[0]}, 32'h0);
    tick();
    idle();
    chk("sb_set", {31'b0, ifa.rd_busy[0]}, 32'h1);
    wr_a(0, 4'd9, 32'h99);
    #1;
    chk("sb_byp_clear", {31'b0, ifa.rd_busy[0]}, 32'h0);
    tick();
    idle();
    chk("sb_cleared", {31'b0, ifa.rd_busy[0]}, 32'h0);
    chk("sb_data", da(0), 32'h99);
    set_a(4'd9);
    wr_a(1, 4'd9, 32'h9A);
    tick();
    idle();
    chk("sb_set_and_wr", {31'b0, ifa.rd_busy[0]}, 32'h1);
    set_a(4'd9);
    wr_a(0, 4'd9, 32'h9B);
    #1;
    chk("sb_set_wins_comb", {31'b0, ifa.rd_busy[0]}, 32'h1);
    tick();
    idle();
    chk("sb_set_wins", {31'b0, ifa.rd_busy[0]}, 32'h1);
    chk("sb_data2", da(0), 32'h9B);

    // port sweep: x1..x15 = i*0x10, two writes per cycle
    for (int i = 1; i < 16; i += 2) begin
      wr_a(0, 4'(i), 32'(i * 16));
      if (i + 1 < 16) wr_a(1, 4'(i + 1), 32'((i + 1) * 16));
      tick();
      idle();
    end
    for (int p = 0; p < 8; p++) ra(p, 4'(2 * p + 1));
    #1;
    for (int p = 0; p < 8; p++) chk($sformatf("sweep_odd_p%0d", p), da(p), 32'((2 * p + 1) * 16));
    for (int p = 0; p < 8; p++) ra(p, 4'(p + 8));
    #1;
    for (int p = 0; p < 8; p++) chk($sformatf("sweep_hi_p%0d", p), da(p), 32'((p + 8) * 16));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/riscv_mp_rf.md
# riscv_mp_rf

Parametrised multi-port integer register file for the RISC-V core, the next generation of the fixed two-read/one-write register file. It provides configurable read and write port counts, an optional same-cycle write-to-read bypass and a per-register pending (scoreboard) bit, so a wider issue stage can check operand hazards directly at the register file. It sits between the decode/issue stage (read and pending-set side) and the writeback stage (write side).

## Interface
- NUM_REGS, 32: architectural registers; power of two, ≥ 2.
- DATA_WIDTH, 32: register width in bits.
- NUM_RD_PORTS, 2: read ports, 1–8.
- NUM_WR_PORTS, 1: write ports, 1–4.
- BYPASS, 1: 1 = same-cycle write data forwarded to matching reads; 0 = reads return stored value only.
- ADDR_W, $clog2(NUM_REGS): derived local parameter, not overridable.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset. Reset is asynchronous and active-low (asynchronous assert; release synchronous to clk upstream).
- rd_addr  in  NUM_RD_PORTS*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD_PORTS*DATA_WIDTH  read data, combinational from rd_addr.
- rd_busy  out  NUM_RD_PORTS  pending bit of the register addressed by port i.
- wr_en  in  NUM_WR_PORTS  write enable per write port.
- wr_addr  in  NUM_WR_PORTS*ADDR_W  write addresses.
- wr_data  in  NUM_WR_PORTS*DATA_WIDTH  write data.
- pend_set  in  1  mark pend_addr pending (new producer issued).
- pend_addr  in  ADDR_W  register to mark pending.

## Operation
- Storage: NUM_REGS x DATA_WIDTH flops plus a NUM_REGS-bit pending vector. Register 0 has no storage. It always reads 0 and is never pending.
- Reset (rst_n low): all registers clear to 0 and all pending bits clear immediately. Outputs during reset: rd_data = 0 on every port, rd_busy = 0.
- Write: on posedge, each port with wr_en=1 and wr_addr≠0 writes wr_data. Writes to address 0 are discarded.
- Write conflict: when several enabled ports target the same address, the highest-index port wins. All others to that address are dropped.
- Read: rd_data[i] = reg[rd_addr[i]]. Address 0 returns 0.
- Bypass (BYPASS=1): if any enabled write port targets rd_addr[i]≠0 in the same cycle, rd_data[i] = that write data, using the same highest-index-wins rule. With BYPASS=0, the stored value is returned; the new value is visible from the next cycle.
- Pending clear: on posedge, any enabled write to address a≠0 clears pend[a].
- Pending set: on posedge, pend_set=1 with pend_addr≠0 sets pend[pend_addr]. pend_set to address 0 is ignored.
- Simultaneous set and clear of the same address: set wins, so pend stays 1 (new producer overrides the retiring one).
- rd_busy[i] = pend[rd_addr[i]]. With BYPASS=1, rd_busy[i] reads 0 when a same-cycle enabled write hits rd_addr[i] and pend_set does not target it in that cycle.
- No handshake. Every write and set is accepted unconditionally. Backpressure is the issue stage's responsibility.

## Timing
- Read latency 0 (combinational). Write latency 1: value stored at the posedge where wr_en is sampled.
- Pending set or clear is visible on rd_busy in the cycle after the edge, or in the same cycle through the bypass term as specified above.
- Reset asserted mid-write: the write is lost and the register reads 0. The first posedge after release performs normal writes.
- No combinational path from wr_* to rd_* when BYPASS=0.

## Test plan
- Reset: load x5=0xDEADBEEF, pend[5]=1, assert rst_n=0 between edges → rd_data for x5 reads 0 and rd_busy=0 immediately, before the next clk edge.
- x0 protection: wr_en[0]=1, wr_addr=0, wr_data=0xFFFFFFFF, plus pend_set to 0 → x0 reads 0 and rd_busy=0 on all ports.
- Write conflict (NUM_WR_PORTS=2): port0 writes x7=0x11, port1 writes x7=0x22 in the same cycle → x7 reads 0x22 the next cycle.
- Bypass: BYPASS=1, write x3=0xA5A5 while reading x3 (old value 0x1) → rd_data=0xA5A5 in the same cycle. With BYPASS=0 → 0x1 that cycle, 0xA5A5 the next.
- Scoreboard: pend_set x9 → rd_busy=1 the next cycle. Write x9 → rd_busy=0 after that edge. Then pend_set x9 together with a write to x9 in the same cycle → rd_busy stays 1.
- Port sweep (NUM_RD_PORTS=8, NUM_REGS=16): write x1..x15 = index*0x10, then read all eight ports at distinct addresses → every port returns its matching value.
